rf_wb_buffer: RTL and testbench

- Writer-side companion to the 8-entry register file.
- Accepts write-back results from two producers, ALU (src0) and memory (src1), through valid/ready handshakes.
- Buffers them in order in a small FIFO and drains one entry per cycle into the register file's write, writeregsel and writedata inputs.
- Exposes two bypass lookup ports so decode can read pending, not-yet-committed values.

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/rf_wb_match.sv | 34 +++
 rtl/rf_wb_buffer.sv | 125 ++++++++++++
 tb/tb_rf_wb_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared register-file constants and write-back entry type
package rf_wb_pkg;

  localparam int RF_SEL_W = 3;
  localparam int RF_NREGS = 8;
  localparam int RF_WIDTH = 16;

  typedef struct packed {
    logic [RF_SEL_W-1:0] sel;
    logic [RF_WIDTH-1:0] data;
  } wb_entry;

endpackage

// File: rtl/rf_wb_match.sv
// rtl/rf_wb_match.sv - newest-first search of pending write-back entries for one register
module rf_wb_match
  import rf_wb_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][RF_SEL_W-1:0] ent_sel,
  input  logic [DEPTH-1:0][WIDTH-1:0]    ent_data,
  input  logic [DEPTH-1:0]               ent_vld,
  input  logic [PW-1:0]                  wr_ptr,
  input  logic [RF_SEL_W-1:0]            sel,
  output logic                           hit,
  output logic [WIDTH-1:0]               data
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (wr_ptr) to the newest (wr_ptr-1) so later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (ent_vld[idx] && (ent_sel[idx] == sel)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/rf_wb_buffer.sv
// rtl/rf_wb_buffer.sv - two-source in-order write-back FIFO feeding the register file, with bypass lookups
module rf_wb_buffer
  import rf_wb_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src0_valid,
  output logic                      src0_ready,
  input  logic [RF_SEL_W-1:0]       src0_regsel,
  input  logic [WIDTH-1:0]          src0_data,
  input  logic                      src1_valid,
  output logic                      src1_ready,
  input  logic [RF_SEL_W-1:0]       src1_regsel,
  input  logic [WIDTH-1:0]          src1_data,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      write,
  output logic [RF_SEL_W-1:0]       writeregsel,
  output logic [WIDTH-1:0]          writedata,
  input  logic [RF_SEL_W-1:0]       lkp1sel,
  output logic                      lkp1hit,
  output logic [WIDTH-1:0]          lkp1data,
  input  logic [RF_SEL_W-1:0]       lkp2sel,
  output logic                      lkp2hit,
  output logic [WIDTH-1:0]          lkp2data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;
  logic [DEPTH-1:0]              ent_vld;
  logic [DEPTH-1:0][RF_SEL_W-1:0] ent_sel;
  logic [DEPTH-1:0][WIDTH-1:0]   ent_data;

  logic                full;
  logic                empty;
  logic                enq;
  logic                deq;
  logic [RF_SEL_W-1:0] enq_sel;
  logic [WIDTH-1:0]    enq_data;
  logic                m1_hit;
  logic                m2_hit;
  logic [WIDTH-1:0]    m1_data;
  logic [WIDTH-1:0]    m2_data;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Readiness looks only at the registered count; a same-cycle pop never frees a slot early.
  assign src0_ready = !full && !flush;
  assign src1_ready = !full && !flush && !src0_valid;

  assign enq      = (src0_valid && src0_ready) || (src1_valid && src1_ready);
  assign enq_sel  = src0_valid ? src0_regsel : src1_regsel;
  assign enq_data = src0_valid ? src0_data   : src1_data;

  assign write       = !empty && !hold && !flush && rst;
  assign deq         = write;
  assign writeregsel = empty ? '0 : ent_sel[rd_ptr];
  assign writedata   = empty ? '0 : ent_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (deq) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (enq) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; the valid bits and count guard every use.
  always_ff @(posedge clk) begin
    if (enq && rst) begin
      ent_sel[wr_ptr]  <= enq_sel;
      ent_data[wr_ptr] <= enq_data;
    end
  end

  rf_wb_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match1 (
    .ent_sel  (ent_sel),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .wr_ptr   (wr_ptr),
    .sel      (lkp1sel),
    .hit      (m1_hit),
    .data     (m1_data)
  );

  rf_wb_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match2 (
    .ent_sel  (ent_sel),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .wr_ptr   (wr_ptr),
    .sel      (lkp2sel),
    .hit      (m2_hit),
    .data     (m2_data)
  );

  // A flushing cycle must not forward entries that are about to be discarded.
  assign lkp1hit  = m1_hit && !flush;
  assign lkp1data = flush ? '0 : m1_data;
  assign lkp2hit  = m2_hit && !flush;
  assign lkp2data = flush ? '0 : m2_data;

endmodule

// File: tb/tb_rf_wb_buffer.sv
// tb/tb_rf_wb_buffer.sv - randomized and directed bench for rf_wb_buffer against a queue model
module tb_rf_wb_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         src0_valid, src0_ready;
  logic [2:0]   src0_regsel;
  logic [W-1:0] src0_data;
  logic         src1_valid, src1_ready;
  logic [2:0]   src1_regsel;
  logic [W-1:0] src1_data;
  logic         hold, flush;
  logic         write;
  logic [2:0]   writeregsel;
  logic [W-1:0] writedata;
  logic [2:0]   lkp1sel, lkp2sel;
  logic         lkp1hit, lkp2hit;
  logic [W-1:0] lkp1data, lkp2data;
  logic [2:0]   count;

  always #5 clk = ~clk;

  rf_wb_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_regsel(src0_regsel), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_regsel(src1_regsel), .src1_data(src1_data),
    .hold(hold), .flush(flush),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .lkp1sel(lkp1sel), .lkp1hit(lkp1hit), .lkp1data(lkp1data),
    .lkp2sel(lkp2sel), .lkp2hit(lkp2hit), .lkp2data(lkp2data),
    .count(count)
  );

  typedef struct {
    logic [2:0]   s;
    logic [W-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   known = 1'b0;
  bit   acc0, acc1;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void lookup(input logic [2:0] s, output logic h, output logic [W-1:0] d);
    h = 1'b0;
    d = '0;
    if (!flush) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].s == s) begin
          h = 1'b1;
          d = q[i].d;
          break;
        end
      end
    end
  endfunction

  // Called just after a falling edge with inputs driven; checks, advances the model past the rising edge.
  task automatic tick();
    logic         full, er0, er1, ew, h;
    logic [W-1:0] d;
    ent_t         e;
    #1;
    full = (q.size() == D);
    er0  = !full && !flush;
    er1  = er0 && !src0_valid;
    ew   = rst && !flush && !hold && (q.size() > 0);
    acc0 = src0_valid && er0;
    acc1 = src1_valid && er1;
    if (known) begin
      chk("src0_ready", 32'(src0_ready), 32'(er0));
      chk("src1_ready", 32'(src1_ready), 32'(er1));
      chk("write", 32'(write), 32'(ew));
      chk("writeregsel", 32'(writeregsel), (q.size() > 0) ? 32'(q[0].s) : 32'd0);
      chk("writedata", 32'(writedata), (q.size() > 0) ? 32'(q[0].d) : 32'd0);
      chk("count", 32'(count), 32'(q.size()));
      lookup(lkp1sel, h, d);
      chk("lkp1hit", 32'(lkp1hit), 32'(h));
      chk("lkp1data", 32'(lkp1data), 32'(d));
      lookup(lkp2sel, h, d);
      chk("lkp2hit", 32'(lkp2hit), 32'(h));
      chk("lkp2data", 32'(lkp2data), 32'(d));
    end
    if (!rst) begin
      q.delete();
      known = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ew) void'(q.pop_front());
      if (acc0) begin
        e.s = src0_regsel; e.d = src0_data; q.push_back(e);
      end else if (acc1) begin
        e.s = src1_regsel; e.d = src1_data; q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    hold       = 1'b0;
    flush      = 1'b0;
    rst        = 1'b1;
  endtask

  task automatic push0(input logic [2:0] s, input logic [W-1:0] d);
    int n = 0;
    src0_valid = 1'b1; src0_regsel = s; src0_data = d;
    do begin
      tick();
      n++;
    end while (!acc0 && n < 10);
    if (!acc0) chk("src0_accept_timeout", 32'd0, 32'd1);
    src0_valid = 1'b0;
  endtask

  initial begin
    idle();
    src0_regsel = '0; src0_data = '0; src1_regsel = '0; src1_data = '0;
    lkp1sel = 3'd3; lkp2sel = 3'd1;
    @(negedge clk);

    // reset then a single write
    rst = 1'b0; tick(); tick();
    rst = 1'b1;
    push0(3'd3, 16'hBEEF);
    tick(); tick();

    // src0 priority over src1
    src0_valid = 1'b1; src0_regsel = 3'd1; src0_data = 16'h0011;
    src1_valid = 1'b1; src1_regsel = 3'd2; src1_data = 16'h0022;
    tick();
    src0_valid = 1'b0;
    for (int n = 0; n < 10 && !acc1; n++) tick();
    if (!acc1) chk("src1_accept_timeout", 32'd0, 32'd1);
    src1_valid = 1'b0;
    tick(); tick(); tick();

    // fill to full under hold, then drain with wrap
    hold = 1'b1;
    for (int s = 0; s < 4; s++) push0(3'(s), 16'h1000 + 16'(s));
    src0_valid = 1'b1; src0_regsel = 3'd4; src0_data = 16'h1004;
    tick(); tick();
    hold = 1'b0;
    push0(3'd4, 16'h1004);
    for (int n = 0; n < 6; n++) tick();

    // bypass newest-wins
    hold = 1'b1;
    lkp1sel = 3'd5; lkp2sel = 3'd7;
    push0(3'd5, 16'h0A0A);
    push0(3'd6, 16'h0B0B);
    push0(3'd5, 16'h0C0C);
    tick();

    // flush with simultaneous enqueue
    flush = 1'b1; src0_valid = 1'b1; src0_regsel = 3'd5; src0_data = 16'hDEAD;
    tick();
    flush = 1'b0; src0_valid = 1'b0;
    tick();

    // reset mid-drain
    push0(3'd2, 16'h2222);
    push0(3'd3, 16'h3333);
    hold = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick(); tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      src0_valid = ($urandom_range(0, 2) == 0);
      src0_regsel = 3'($urandom_range(0, 7));
      src0_data = 16'($urandom);
      if (!(src1_valid && !acc1)) begin
        src1_valid = $urandom_range(0, 1) == 1;
        src1_regsel = 3'($urandom_range(0, 7));
        src1_data = 16'($urandom);
      end
      lkp1sel = 3'($urandom_range(0, 7));
      lkp2sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
